btb_predictor: RTL and testbench

Parametrised branch target buffer with 2-bit saturating direction counters, replacing the fixed single-entry BTB in the ThinPad 5-stage pipeline. Sits beside `PC_reg`: IF-stage lookup on the current PC gives a predicted next PC. EXE-stage resolution updates the table and raises a mispredict/recovery request that drives `pcKeep`/flush logic in `hazard`. The block also supports a whole-table flush and optional hit/mispredict statistics.

---
 rtl/btb_predictor.sv | 115 +++++++++++
 tb/tb_btb_predictor.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Define BTB_STATS_EN to add saturating hit/mispredict statistics outputs.
module btb_predictor #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned ENTRIES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cur_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_pc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_pc,
  input  logic              flush,
  output logic              mispredict,
  output logic [ADDR_W-1:0] recover_pc
`ifdef BTB_STATS_EN
  ,
  output logic [15:0]       stat_hits,
  output logic [15:0]       stat_mispred
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;

  logic [ENTRIES-1:0]             valid_q;
  logic [ENTRIES-1:0][1:0]        ctr_q;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
  logic [ENTRIES-1:0][ADDR_W-1:0] target_q;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       upd_ctr;
  logic [1:0]       ctr_nxt;
  logic             upd_en;

  // IF-stage lookup, purely combinational on the pre-update table
  assign lk_idx     = cur_pc[IDX_W-1:0];
  assign lk_tag     = cur_pc[ADDR_W-1:IDX_W];
  assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken = lk_hit && ctr_q[lk_idx][1];
  assign pred_pc    = pred_taken ? target_q[lk_idx] : cur_pc + ADDR_W'(1);

  // EXE-stage resolution check
  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_pred_pc != upd_target)));
  assign recover_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(1);

  assign upd_idx = upd_pc[IDX_W-1:0];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_ctr = ctr_q[upd_idx];
  assign upd_en  = upd_valid && !flush;

  // Saturating counter step for a hitting update
  always_comb begin
    ctr_nxt = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != 2'd3) ctr_nxt = upd_ctr + 2'd1;
    end else begin
      if (upd_ctr != 2'd0) ctr_nxt = upd_ctr - 2'd1;
    end
  end

  // Valid bits and direction counters carry reset state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      ctr_q   <= {ENTRIES{2'd1}};
    end else if (flush) begin
      valid_q <= '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_nxt;
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= 2'd2;
      end
    end
  end

  // Tag and target are only meaningful behind a set valid bit, so no reset
  always_ff @(posedge clk) begin
    if (upd_en && upd_taken) begin
      target_q[upd_idx] <= upd_target;
      if (!upd_hit) tag_q[upd_idx] <= upd_tag;
    end
  end

`ifdef BTB_STATS_EN
  // Statistics survive flush; only reset clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits    <= 16'd0;
      stat_mispred <= 16'd0;
    end else begin
      if (upd_valid && upd_hit && (stat_hits != 16'hFFFF))
        stat_hits <= stat_hits + 16'd1;
      if (mispredict && (stat_mispred != 16'hFFFF))
        stat_mispred <= stat_mispred + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: rows push expected lookup/resolution
// results, which are popped and compared mid-cycle against the DUT.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cur_pc;
  logic        pred_taken;
  logic [15:0] pred_pc;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        upd_pred_taken;
  logic [15:0] upd_pred_pc;
  logic        flush;
  logic        mispredict;
  logic [15:0] recover_pc;
`ifdef BTB_STATS_EN
  logic [15:0] stat_hits;
  logic [15:0] stat_mispred;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] lpc;
    logic        uv;
    logic [15:0] upc;
    logic        ut;
    logic [15:0] utgt;
    logic        uppt;
    logic [15:0] uppc;
    logic        fl;
    logic        ept;
    logic [15:0] eppc;
    logic        emp;
    logic [15:0] erpc;
  } row_t;

  row_t exp_q[$];

  btb_predictor #(.ADDR_W(16), .ENTRIES(8)) dut (
    .clk(clk), .rst(rst), .cur_pc(cur_pc),
    .pred_taken(pred_taken), .pred_pc(pred_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_pc(upd_pred_pc), .flush(flush),
    .mispredict(mispredict), .recover_pc(recover_pc)
`ifdef BTB_STATS_EN
    , .stat_hits(stat_hits), .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  function automatic row_t mk(input logic [15:0] lpc, input logic uv,
                              input logic [15:0] upc, input logic ut,
                              input logic [15:0] utgt, input logic uppt,
                              input logic [15:0] uppc, input logic fl,
                              input logic ept, input logic [15:0] eppc,
                              input logic emp, input logic [15:0] erpc);
    row_t r;
    r.lpc = lpc; r.uv = uv; r.upc = upc; r.ut = ut; r.utgt = utgt;
    r.uppt = uppt; r.uppc = uppc; r.fl = fl;
    r.ept = ept; r.eppc = eppc; r.emp = emp; r.erpc = erpc;
    return r;
  endfunction

  // Apply one row for exactly one rising edge and queue its expectations
  task automatic drive_row(input row_t r);
    @(posedge clk); #1;
    cur_pc = r.lpc; upd_valid = r.uv; upd_pc = r.upc; upd_taken = r.ut;
    upd_target = r.utgt; upd_pred_taken = r.uppt; upd_pred_pc = r.uppc;
    flush = r.fl;
    exp_q.push_back(r);
  endtask

  task automatic test_reset;
    row_t e;
    rst = 1'b1;
    cur_pc = 16'h0040; upd_valid = 1'b1; upd_pc = 16'h0040; upd_taken = 1'b1;
    upd_target = 16'h0300; upd_pred_taken = 1'b0; upd_pred_pc = 16'h0041;
    flush = 1'b0;
    exp_q.push_back(mk(16'h0040, 1, 16'h0040, 1, 16'h0300, 0, 16'h0041, 0,
                       0, 16'h0041, 1, 16'h0300));
    repeat (2) @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (pred_taken !== e.ept || pred_pc !== e.eppc) begin
      errors++;
      $display("FAIL reset lookup: got %b/%h want %b/%h", pred_taken, pred_pc, e.ept, e.eppc);
    end
    checks++;
    if (mispredict !== e.emp || recover_pc !== e.erpc) begin
      errors++;
      $display("FAIL reset mispredict: got %b/%h want %b/%h", mispredict, recover_pc, e.emp, e.erpc);
    end
    // Update held during reset must not have allocated
    @(posedge clk); #1;
    rst = 1'b0; upd_valid = 1'b0;
    exp_q.push_back(mk(16'h0040, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0041, 0, 0));
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (pred_taken !== e.ept || pred_pc !== e.eppc || mispredict !== e.emp) begin
      errors++;
      $display("FAIL reset_release lookup: got %b/%h/%b want %b/%h/%b",
               pred_taken, pred_pc, mispredict, e.ept, e.eppc, e.emp);
    end
  endtask

  // Runs a table of rows; shared by nothing else, compares inline
  task automatic test_alloc;
    row_t rows[2];
    row_t e;
    rows[0] = mk(16'h0043, 1, 16'h0043, 1, 16'h0100, 0, 16'h0044, 0, 0, 16'h0044, 1, 16'h0100);
    rows[1] = mk(16'h0043, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0100, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive_row(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (pred_taken !== e.ept || pred_pc !== e.eppc) begin
        errors++;
        $display("FAIL alloc lookup row %0d: got %b/%h want %b/%h", i, pred_taken, pred_pc, e.ept, e.eppc);
      end
      checks++;
      if (mispredict !== e.emp || (e.emp && recover_pc !== e.erpc)) begin
        errors++;
        $display("FAIL alloc resolve row %0d: got %b/%h want %b/%h", i, mispredict, recover_pc, e.emp, e.erpc);
      end
    end
  endtask

  task automatic test_hysteresis;
    row_t rows[9];
    row_t e;
    rows[0] = mk(16'h0043, 1, 16'h0043, 0, 16'h0000, 1, 16'h0100, 0, 1, 16'h0100, 1, 16'h0044);
    rows[1] = mk(16'h0043, 1, 16'h0043, 0, 16'h0000, 0, 16'h0044, 0, 0, 16'h0044, 0, 16'h0000);
    rows[2] = mk(16'h0043, 1, 16'h0043, 0, 16'h0000, 0, 16'h0044, 0, 0, 16'h0044, 0, 16'h0000);
    rows[3] = mk(16'h0043, 1, 16'h0043, 1, 16'h0100, 0, 16'h0044, 0, 0, 16'h0044, 1, 16'h0100);
    rows[4] = mk(16'h0043, 1, 16'h0043, 1, 16'h0100, 0, 16'h0044, 0, 0, 16'h0044, 1, 16'h0100);
    rows[5] = mk(16'h0043, 1, 16'h0043, 1, 16'h0100, 1, 16'h0100, 0, 1, 16'h0100, 0, 16'h0000);
    rows[6] = mk(16'h0043, 1, 16'h0043, 1, 16'h0100, 1, 16'h0100, 0, 1, 16'h0100, 0, 16'h0000);
    rows[7] = mk(16'h0043, 1, 16'h0043, 0, 16'h0000, 1, 16'h0100, 0, 1, 16'h0100, 1, 16'h0044);
    rows[8] = mk(16'h0043, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0100, 0, 0);
    for (int i = 0; i < 9; i++) begin
      drive_row(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (pred_taken !== e.ept || pred_pc !== e.eppc) begin
        errors++;
        $display("FAIL hysteresis lookup row %0d: got %b/%h want %b/%h", i, pred_taken, pred_pc, e.ept, e.eppc);
      end
      checks++;
      if (mispredict !== e.emp || (e.emp && recover_pc !== e.erpc)) begin
        errors++;
        $display("FAIL hysteresis resolve row %0d: got %b/%h want %b/%h", i, mispredict, recover_pc, e.emp, e.erpc);
      end
    end
  endtask

  task automatic test_alias;
    row_t rows[5];
    row_t e;
    rows[0] = mk(16'h0043, 1, 16'h00A3, 1, 16'h0200, 0, 16'h00A4, 0, 1, 16'h0100, 1, 16'h0200);
    rows[1] = mk(16'h0043, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0044, 0, 0);
    rows[2] = mk(16'h00A3, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0200, 0, 0);
    rows[3] = mk(16'h00A3, 1, 16'h00A3, 1, 16'h0250, 1, 16'h0200, 0, 1, 16'h0200, 1, 16'h0250);
    rows[4] = mk(16'h00A3, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0250, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive_row(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (pred_taken !== e.ept || pred_pc !== e.eppc) begin
        errors++;
        $display("FAIL alias lookup row %0d: got %b/%h want %b/%h", i, pred_taken, pred_pc, e.ept, e.eppc);
      end
      checks++;
      if (mispredict !== e.emp || (e.emp && recover_pc !== e.erpc)) begin
        errors++;
        $display("FAIL alias resolve row %0d: got %b/%h want %b/%h", i, mispredict, recover_pc, e.emp, e.erpc);
      end
    end
  endtask

  task automatic test_flush;
    row_t rows[4];
    row_t e;
    rows[0] = mk(16'h00A3, 1, 16'h0045, 1, 16'h0123, 0, 16'h0046, 1, 1, 16'h0250, 1, 16'h0123);
    rows[1] = mk(16'h0045, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0046, 0, 0);
    rows[2] = mk(16'h00A3, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00A4, 0, 0);
    rows[3] = mk(16'h0043, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0044, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive_row(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (pred_taken !== e.ept || pred_pc !== e.eppc) begin
        errors++;
        $display("FAIL flush lookup row %0d: got %b/%h want %b/%h", i, pred_taken, pred_pc, e.ept, e.eppc);
      end
      checks++;
      if (mispredict !== e.emp || (e.emp && recover_pc !== e.erpc)) begin
        errors++;
        $display("FAIL flush resolve row %0d: got %b/%h want %b/%h", i, mispredict, recover_pc, e.emp, e.erpc);
      end
    end
  endtask

  task automatic test_wrap;
    row_t rows[2];
    row_t e;
    rows[0] = mk(16'hFFFF, 1, 16'hFFFF, 0, 16'h0000, 1, 16'h1234, 0, 0, 16'h0000, 1, 16'h0000);
    // Inputs disagree but upd_valid is low: no mispredict
    rows[1] = mk(16'hFFFF, 0, 16'hFFFF, 1, 16'h0777, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      drive_row(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (pred_taken !== e.ept || pred_pc !== e.eppc) begin
        errors++;
        $display("FAIL wrap lookup row %0d: got %b/%h want %b/%h", i, pred_taken, pred_pc, e.ept, e.eppc);
      end
      checks++;
      if (mispredict !== e.emp || (e.emp && recover_pc !== e.erpc)) begin
        errors++;
        $display("FAIL wrap resolve row %0d: got %b/%h want %b/%h", i, mispredict, recover_pc, e.emp, e.erpc);
      end
    end
  endtask

  task automatic test_back_to_back;
    row_t rows[3];
    row_t e;
    rows[0] = mk(16'h0010, 1, 16'h0010, 1, 16'h0500, 0, 16'h0011, 0, 0, 16'h0011, 1, 16'h0500);
    rows[1] = mk(16'h0010, 1, 16'h0011, 1, 16'h0600, 0, 16'h0012, 0, 1, 16'h0500, 1, 16'h0600);
    rows[2] = mk(16'h0011, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0600, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive_row(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (pred_taken !== e.ept || pred_pc !== e.eppc) begin
        errors++;
        $display("FAIL b2b lookup row %0d: got %b/%h want %b/%h", i, pred_taken, pred_pc, e.ept, e.eppc);
      end
      checks++;
      if (mispredict !== e.emp || (e.emp && recover_pc !== e.erpc)) begin
        errors++;
        $display("FAIL b2b resolve row %0d: got %b/%h want %b/%h", i, mispredict, recover_pc, e.emp, e.erpc);
      end
    end
  endtask

`ifdef BTB_STATS_EN
  task automatic test_stats;
    row_t rows[7];
    row_t e;
    @(posedge clk); #1;
    rst = 1'b1; upd_valid = 1'b0; flush = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (stat_hits !== 16'd0 || stat_mispred !== 16'd0) begin
      errors++;
      $display("FAIL stats reset: got %0d/%0d want 0/0", stat_hits, stat_mispred);
    end
    rows[0] = mk(16'h0020, 1, 16'h0020, 1, 16'h0700, 0, 16'h0021, 0, 0, 16'h0021, 1, 16'h0700);
    rows[1] = mk(16'h0020, 1, 16'h0030, 0, 16'h0000, 1, 16'h0999, 0, 1, 16'h0700, 1, 16'h0031);
    rows[2] = mk(16'h0020, 1, 16'h0038, 0, 16'h0000, 1, 16'h0999, 0, 1, 16'h0700, 1, 16'h0039);
    rows[3] = mk(16'h0020, 1, 16'h0020, 1, 16'h0700, 1, 16'h0700, 0, 1, 16'h0700, 0, 16'h0000);
    rows[4] = mk(16'h0020, 1, 16'h0020, 1, 16'h0700, 1, 16'h0700, 0, 1, 16'h0700, 0, 16'h0000);
    rows[5] = mk(16'h0020, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0700, 0, 0);
    rows[6] = mk(16'h0020, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0021, 0, 0);
    for (int i = 0; i < 7; i++) begin
      drive_row(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (pred_taken !== e.ept || pred_pc !== e.eppc ||
          mispredict !== e.emp || (e.emp && recover_pc !== e.erpc)) begin
        errors++;
        $display("FAIL stats row %0d: got %b/%h/%b/%h want %b/%h/%b/%h", i, pred_taken, pred_pc,
                 mispredict, recover_pc, e.ept, e.eppc, e.emp, e.erpc);
      end
    end
    checks++;
    if (stat_hits !== 16'd2 || stat_mispred !== 16'd3) begin
      errors++;
      $display("FAIL stats counts: got hits=%0d mispred=%0d want hits=2 mispred=3", stat_hits, stat_mispred);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alloc();
    test_hysteresis();
    test_alias();
    test_flush();
    test_wrap();
    test_back_to_back();
`ifdef BTB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
